// File: rtl/vigna_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vigna_mem_arbiter
// Description : Two-master arbiter sharing one native memory port between the
//               instruction-fetch port (I) and the load/store port (D).
//               One transaction at a time, with one idle cycle between
//               transactions so the downstream adapter can settle.
// Revision    : 1.0 - initial release
// ============================================================================
module vigna_mem_arbiter #(
   parameter int ROUND_ROBIN = 1,
   parameter int DATA_FIRST  = 1
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        i_valid,
   output logic        i_ready,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,

   input  logic        d_valid,
   output logic        d_ready,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic [31:0] d_rdata,

   output logic        mem_valid,
   output logic        mem_instr,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } state_t;

   state_t r_state;
   logic   r_last_d;
   logic   r_mem_valid;
   logic   r_mem_instr;

   logic   w_tie_d;
   logic   w_grant_d;
   logic   w_grant_i;

   // Choose the winner among the current requests; only consumed while idle
   always_comb begin
      w_tie_d   = (ROUND_ROBIN != 0) ? ~r_last_d : (DATA_FIRST != 0);
      w_grant_d = d_valid & (~i_valid | w_tie_d);
      w_grant_i = i_valid & ~w_grant_d;
   end

   // Grant state machine; mem_valid/mem_instr are registered alongside the state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_last_d    <= 1'b0;
         r_mem_valid <= 1'b0;
         r_mem_instr <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant_d) begin
                  r_state     <= ST_BUSY_D;
                  r_last_d    <= 1'b1;
                  r_mem_valid <= 1'b1;
                  r_mem_instr <= 1'b0;
               end else if (w_grant_i) begin
                  r_state     <= ST_BUSY_I;
                  r_last_d    <= 1'b0;
                  r_mem_valid <= 1'b1;
                  r_mem_instr <= 1'b1;
               end
            end
            ST_BUSY_I, ST_BUSY_D: begin
               // Grant is held until the shared port completes, regardless of valid
               if (mem_ready) begin
                  r_state     <= ST_IDLE;
                  r_mem_valid <= 1'b0;
                  r_mem_instr <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_mem_valid <= 1'b0;
               r_mem_instr <= 1'b0;
            end
         endcase
      end
   end

   // Route the granted master onto the shared port; zero while idle, I never writes
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      case (r_state)
         ST_BUSY_I: begin
            mem_addr = i_addr;
         end
         ST_BUSY_D: begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wstrb = d_wstrb;
         end
         default: begin
         end
      endcase
   end

   assign mem_valid = r_mem_valid;
   assign mem_instr = r_mem_instr;

   // Completion goes only to the granted master; a stray mem_ready while idle is dropped
   assign i_ready = mem_ready & (r_state == ST_BUSY_I);
   assign d_ready = mem_ready & (r_state == ST_BUSY_D);

   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_vigna_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vigna_mem_arbiter
// Description : Scoreboard bench for vigna_mem_arbiter. Random masters and a
//               random-latency slave drive a round-robin instance; a second
//               instance exercises fixed data-first priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vigna_mem_arbiter;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Round-robin instance signals
   logic        i_valid, i_ready, d_valid, d_ready;
   logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
   logic [3:0]  d_wstrb;
   logic        mem_valid, mem_instr, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   // Fixed-priority instance signals
   logic        fp_i_valid, fp_i_ready, fp_d_valid, fp_d_ready;
   logic [31:0] fp_i_addr, fp_i_rdata, fp_d_addr, fp_d_wdata, fp_d_rdata;
   logic [3:0]  fp_d_wstrb;
   logic        fp_mem_valid, fp_mem_instr;
   logic        fp_mem_ready = 1'b0;
   logic [31:0] fp_mem_addr, fp_mem_wdata;
   logic [31:0] fp_mem_rdata = 32'hF00D_0000;
   logic [3:0]  fp_mem_wstrb;

   vigna_mem_arbiter #(.ROUND_ROBIN(1), .DATA_FIRST(1)) dut (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
      .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(d_rdata),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata)
   );

   vigna_mem_arbiter #(.ROUND_ROBIN(0), .DATA_FIRST(1)) dut_fp (
      .clk(clk), .reset(reset),
      .i_valid(fp_i_valid), .i_ready(fp_i_ready), .i_addr(fp_i_addr), .i_rdata(fp_i_rdata),
      .d_valid(fp_d_valid), .d_ready(fp_d_ready), .d_addr(fp_d_addr), .d_wdata(fp_d_wdata),
      .d_wstrb(fp_d_wstrb), .d_rdata(fp_d_rdata),
      .mem_valid(fp_mem_valid), .mem_instr(fp_mem_instr), .mem_ready(fp_mem_ready),
      .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_wstrb(fp_mem_wstrb),
      .mem_rdata(fp_mem_rdata)
   );

   int total = 0;
   int bad   = 0;

   req_t        q_i[$];
   req_t        q_d[$];
   bit          glog[$];          // mem_instr at each observed grant start
   logic [31:0] slave_rdata = '0;
   bit          slave_en = 1'b0;
   int          slave_maxlat = 3;

   // Reference model: 0 = nobody granted, 1 = I, 2 = D
   int          m_owner = 0;
   bit          m_last_d = 1'b0;
   bit          prev_mv = 1'b0;
   req_t        cur;
   bit          pick_d;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare the shared port and both ready/rdata outputs to the model each cycle
   always @(negedge clk) begin
      if (mem_valid === 1'b1 && !prev_mv) glog.push_back(mem_instr);
      prev_mv = (mem_valid === 1'b1);

      cur = '0;
      if (m_owner != 0) chk("sb_nonempty", (m_owner == 1) ? (q_i.size() > 0) : (q_d.size() > 0), 1);
      if (m_owner == 1 && q_i.size() > 0) begin
         cur.addr = q_i[0].addr;
      end
      if (m_owner == 2 && q_d.size() > 0) cur = q_d[0];

      chk("mem_valid", mem_valid, m_owner != 0);
      chk("mem_instr", mem_instr, m_owner == 1);
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_wdata", mem_wdata, cur.wdata);
      chk("mem_wstrb", mem_wstrb, cur.wstrb);
      chk("i_ready", i_ready, (m_owner == 1) && mem_ready);
      chk("d_ready", d_ready, (m_owner == 2) && mem_ready);
      if (m_owner == 1 && mem_ready) chk("i_rdata", i_rdata, slave_rdata);
      if (m_owner == 2 && mem_ready) chk("d_rdata", d_rdata, slave_rdata);

      // Advance the model by one clock
      if (reset) begin
         m_owner  = 0;
         m_last_d = 1'b0;
      end else if (m_owner != 0) begin
         if (mem_ready) begin
            if (m_owner == 1) void'(q_i.pop_front());
            else              void'(q_d.pop_front());
            m_owner = 0;
         end
      end else if (i_valid || d_valid) begin
         pick_d   = d_valid && (!i_valid || !m_last_d);
         m_owner  = pick_d ? 2 : 1;
         m_last_d = pick_d;
      end
   end

   // Random-latency slave for the round-robin instance
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (slave_en && mem_valid === 1'b1) begin
            repeat (1 + $urandom_range(0, slave_maxlat)) @(posedge clk);
            #1;
            mem_rdata   = $urandom;
            slave_rdata = mem_rdata;
            mem_ready   = 1'b1;
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
         end
      end
   end

   // Fixed-priority instance slave: completes one cycle after each grant
   always @(posedge clk) begin
      if (reset) fp_mem_ready <= 1'b0;
      else       fp_mem_ready <= (fp_mem_valid === 1'b1) && !fp_mem_ready;
   end

   task automatic wait_ready(input bit is_d);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (((is_d ? d_ready : i_ready) !== 1'b1) && c < 400);
      chk(is_d ? "d_ready_timeout" : "i_ready_timeout", is_d ? d_ready : i_ready, 1);
   endtask

   task automatic run_i(input int n, input int maxgap);
      req_t r;
      int   g;
      for (int k = 0; k < n; k++) begin
         g = $urandom_range(0, maxgap);
         if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
         end
         r.addr  = $urandom;
         r.wdata = '0;
         r.wstrb = '0;
         q_i.push_back(r);
         i_addr  = r.addr;
         i_valid = 1'b1;
         wait_ready(1'b0);
         @(posedge clk);
         #1;
         i_valid = 1'b0;
      end
   endtask

   task automatic run_d(input int n, input int maxgap);
      req_t r;
      int   g;
      for (int k = 0; k < n; k++) begin
         g = $urandom_range(0, maxgap);
         if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
         end
         r.addr  = $urandom;
         r.wdata = $urandom;
         r.wstrb = 4'($urandom_range(0, 15));
         q_d.push_back(r);
         d_addr  = r.addr;
         d_wdata = r.wdata;
         d_wstrb = r.wstrb;
         d_valid = 1'b1;
         wait_ready(1'b1);
         @(posedge clk);
         #1;
         d_valid = 1'b0;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      req_t r;
      int   ngrant, nd, n_i_early;
      bit   done, fprev;

      reset   = 1'b1;
      i_valid = 1'b0; i_addr = '0;
      d_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
      fp_i_valid = 1'b0; fp_i_addr = '0;
      fp_d_valid = 1'b0; fp_d_addr = '0; fp_d_wdata = '0; fp_d_wstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Random traffic, both masters, random gaps and slave latency
      slave_en     = 1'b1;
      slave_maxlat = 3;
      fork
         run_i(40, 4);
         run_d(40, 4);
      join
      repeat (3) @(posedge clk);
      #1;
      slave_en = 1'b0;

      // Single I read, slave completes three cycles after the request
      r = '0; r.addr = 32'h0000_0100;
      q_i.push_back(r);
      i_addr = 32'h0000_0100; i_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      mem_rdata = 32'hDEAD_BEEF; slave_rdata = 32'hDEAD_BEEF; mem_ready = 1'b1;
      @(negedge clk);
      chk("dir_i_instr", mem_instr, 1);
      chk("dir_i_wstrb", mem_wstrb, 0);
      chk("dir_i_ready", i_ready, 1);
      chk("dir_i_rdata", i_rdata, 32'hDEAD_BEEF);
      chk("dir_i_d_ready", d_ready, 0);
      @(posedge clk);
      #1;
      mem_ready = 1'b0; i_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Single D write
      r.addr = 32'h0000_2000; r.wdata = 32'h1234_5678; r.wstrb = 4'b0011;
      q_d.push_back(r);
      d_addr = r.addr; d_wdata = r.wdata; d_wstrb = r.wstrb; d_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      slave_rdata = mem_rdata; mem_ready = 1'b1;
      @(negedge clk);
      chk("dir_d_addr", mem_addr, 32'h0000_2000);
      chk("dir_d_wdata", mem_wdata, 32'h1234_5678);
      chk("dir_d_wstrb", mem_wstrb, 4'b0011);
      chk("dir_d_instr", mem_instr, 0);
      chk("dir_d_ready", d_ready, 1);
      @(posedge clk);
      #1;
      mem_ready = 1'b0; d_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Stray mem_ready while idle
      mem_ready = 1'b1;
      @(negedge clk);
      chk("stray_i_ready", i_ready, 0);
      chk("stray_d_ready", d_ready, 0);
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("stray_mem_valid", mem_valid, 0);
      @(posedge clk);
      #1;

      // Reset while D is granted, before completion
      r.addr = 32'h0000_3000; r.wdata = 32'hCAFE_F00D; r.wstrb = 4'b1111;
      q_d.push_back(r);
      d_addr = r.addr; d_wdata = r.wdata; d_wstrb = r.wstrb; d_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0; d_valid = 1'b0;
      q_d.delete();
      @(negedge clk);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_d_ready", d_ready, 0);
      @(posedge clk);
      #1;

      // Contention after reset: D wins the first tie, then strict alternation
      glog.delete();
      slave_en     = 1'b1;
      slave_maxlat = 0;
      fork
         run_i(2, 0);
         run_d(2, 0);
      join
      chk("rr_grants", glog.size(), 4);
      if (glog.size() == 4) begin
         chk("rr_grant0_d", glog[0], 0);
         chk("rr_grant1_i", glog[1], 1);
         chk("rr_grant2_d", glog[2], 0);
         chk("rr_grant3_i", glog[3], 1);
      end
      repeat (3) @(posedge clk);
      #1;
      slave_en = 1'b0;

      // Fixed data-first priority: D takes four grants, I starves until D drops
      fp_i_addr = 32'h0000_0040; fp_i_valid = 1'b1;
      fp_d_addr = 32'h0000_0080; fp_d_wdata = 32'hA5A5_5A5A; fp_d_wstrb = 4'hF; fp_d_valid = 1'b1;
      ngrant = 0; nd = 0; n_i_early = 0; done = 1'b0; fprev = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (fp_mem_valid === 1'b1 && !fprev) begin
            if (ngrant < 4) begin
               chk("fp_grant_d", fp_mem_instr, 0);
            end else begin
               chk("fp_grant_i", fp_mem_instr, 1);
               chk("fp_i_addr", fp_mem_addr, 32'h0000_0040);
               chk("fp_i_wstrb", fp_mem_wstrb, 0);
               chk("fp_i_wdata", fp_mem_wdata, 0);
               done = 1'b1;
            end
            ngrant++;
         end
         fprev = (fp_mem_valid === 1'b1);
         if (fp_i_ready === 1'b1 && !done) n_i_early++;
         if (fp_d_ready === 1'b1) nd++;
         if (nd == 4 && fp_d_valid) begin
            @(posedge clk);
            #1;
            fp_d_valid = 1'b0;
         end
      end
      chk("fp_done", done, 1);
      chk("fp_d_count", nd, 4);
      chk("fp_i_starved", n_i_early, 0);
      fp_i_valid = 1'b0;
      repeat (4) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
